// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM state encodings and default operand width for the serial adder.
package serial_adder_ctrl_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational full adder built from two half adders and an OR.
module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_s0, w_c0, w_c1;
    half_adder u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
    half_adder u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));
    assign o_c = w_c0 | w_c1;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder cell.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencer with start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sa, r_sb, r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             w_s, w_co, w_run, w_last, w_accept;

    full_adder_bit u_fa (.i_a(r_sa[0]), .i_b(r_sb[0]), .i_c(r_c), .o_s(w_s), .o_c(w_co));

    assign w_run    = r_state == ST_RUN;
    assign w_last   = w_run && (r_cnt == CW'(WIDTH - 1));
    assign w_accept = start && !w_run;
    assign busy     = w_run;
    assign done     = r_state == ST_DONE;

    always_comb begin
        w_next = w_accept ? ST_RUN : w_run ? (w_last ? ST_DONE : ST_RUN) : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Result bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_c   <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_sa  <= a;
            r_sb  <= b;
            r_res <= '0;
            r_cnt <= '0;
            r_c   <= 1'b0;
        end else if (w_run) begin
            r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
            r_res <= {w_s, r_res[WIDTH-1:1]};
            r_c   <= w_co;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                sum  <= {w_s, r_res[WIDTH-1:1]};
                cout <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= r_c ^ w_co;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench; expected results queued at accepted starts, monitor checks on done.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           dc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   m_done_cyc = -1;
    exp_t q[$];
    logic [W-1:0] prev_sum = '0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Drive a start for one edge; the model decides whether the DUT should accept it.
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
        logic [W:0] full;
        exp_t e;
        @(negedge clk);
        start = 1'b1; a = va; b = vb;
        @(posedge clk); #1;
        if (!rst && cyc > m_done_cyc) begin
            full = {1'b0, va} + {1'b0, vb};
            e.s  = full[W-1:0];
            e.co = full[W];
            e.ov = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
            e.dc = cyc + W;
            q.push_back(e);
            m_done_cyc = e.dc;
        end
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done_cycle();
        for (int i = 0; i < 4 * W && cyc < m_done_cyc; i++) idle(1);
    endtask

    task automatic do_reset(input logic with_start);
        @(negedge clk);
        rst = 1'b1; start = with_start; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        q.delete();
        m_done_cyc = -1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && cyc > q[0].dc) begin
                chk("done_missing", 0, 1);
                void'(q.pop_front());
            end
            chk("busy", 32'(busy), 32'(q.size() > 0 && cyc >= q[0].dc - W && cyc < q[0].dc));
            if (busy) chk("sum_stable", 32'(sum), 32'(prev_sum));
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    chk("done_cycle", 32'(cyc), 32'(q[0].dc));
                    chk("sum", 32'(sum), 32'(q[0].s));
                    chk("cout", 32'(cout), 32'(q[0].co));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", 32'(ovf), 32'(q[0].ov));
`endif
                    void'(q.pop_front());
                end
            end
        end
        prev_sum = sum;
    end

    initial begin
        idle(2);
        do_reset(1'b1);
        issue(8'h00, 8'h00); wait_done_cycle(); idle(2);
        issue(8'h0F, 8'h01); wait_done_cycle(); idle(2);
        issue(8'hFF, 8'h01); wait_done_cycle(); idle(2);
        issue(8'h7F, 8'h01); wait_done_cycle(); idle(2);
        issue(8'h12, 8'h34); idle(1);
        issue(8'hFF, 8'hFF);
        wait_done_cycle();
        issue(8'h01, 8'h01); wait_done_cycle(); idle(2);
        issue(8'hAA, 8'h55); idle(2);
        do_reset(1'b0);
        idle(W + 3);
        issue(8'h80, 8'h80); wait_done_cycle(); idle(1);
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(0, W - 3));
                issue(W'($urandom), W'($urandom));
            end
            wait_done_cycle();
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        for (int i = 0; i < 4 * W && q.size() > 0; i++) idle(1);
        idle(2);
        if (q.size() > 0) chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
